// File: rtl/reset_sequencer.sv
// Board-level reset sequencer. It waits for a stable PLL lock, then releases the
// ADC, DSP and host resets in order, and drops all three on lock loss or soft reset.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int STAGE_DELAY = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       adc_rst_n,
    output logic       dsp_rst_n,
    output logic       host_rst_n,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] fault_count
);

    localparam int MAX_HL = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int MAX_P  = (MAX_HL > STAGE_DELAY) ? MAX_HL : STAGE_DELAY;
    localparam int CNT_W  = $clog2(MAX_P);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL_ADC   = 3'd2,
        ST_REL_DSP   = 3'd3,
        ST_REL_HOST  = 3'd4,
        ST_RUN       = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic [7:0]       fault_q, fault_d;
    logic             adc_q, adc_d;
    logic             dsp_q, dsp_d;
    logic             host_q, host_d;
    logic             ready_q, ready_d;
    logic             pll_sync;
    logic             lock_abort;

    assign pll_sync = sync_q[1];

    // Next-state, counter, fault counter and output decode from the next state.
    always_comb begin
        sync_d  = {sync_q[0], pll_locked};
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        // Lock loss only aborts once lock has been accepted; it outranks soft_reset.
        lock_abort = !pll_sync && (state_q inside {ST_REL_ADC, ST_REL_DSP, ST_REL_HOST, ST_RUN});

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
                else                    state_d = ST_HOLD;
            end
            ST_WAIT_LOCK: begin
                if (soft_reset)                          state_d = ST_HOLD;
                else if (pll_sync && cnt_q == LOCK_LAST) state_d = ST_REL_ADC;
                else                                     state_d = ST_WAIT_LOCK;
            end
            ST_REL_ADC: begin
                if (lock_abort || soft_reset) state_d = ST_HOLD;
                else if (cnt_q == STAGE_LAST) state_d = ST_REL_DSP;
                else                          state_d = ST_REL_ADC;
            end
            ST_REL_DSP: begin
                if (lock_abort || soft_reset) state_d = ST_HOLD;
                else if (cnt_q == STAGE_LAST) state_d = ST_REL_HOST;
                else                          state_d = ST_REL_DSP;
            end
            ST_REL_HOST: begin
                if (lock_abort || soft_reset) state_d = ST_HOLD;
                else if (cnt_q == STAGE_LAST) state_d = ST_RUN;
                else                          state_d = ST_REL_HOST;
            end
            ST_RUN: begin
                if (lock_abort || soft_reset) state_d = ST_HOLD;
                else                          state_d = ST_RUN;
            end
            default: state_d = ST_HOLD;
        endcase

        // Every state exits at its terminal count, so the counter never wraps.
        if (state_d != state_q)                          cnt_d = '0;
        else if (state_q == ST_WAIT_LOCK && !pll_sync)   cnt_d = '0;
        else if (state_q == ST_RUN)                      cnt_d = cnt_q;
        else                                             cnt_d = cnt_q + CNT_W'(1);

        if (lock_abort && fault_q != 8'hFF) fault_d = fault_q + 8'd1;
        else                                fault_d = fault_q;

        adc_d   = (state_d inside {ST_REL_ADC, ST_REL_DSP, ST_REL_HOST, ST_RUN});
        dsp_d   = (state_d inside {ST_REL_DSP, ST_REL_HOST, ST_RUN});
        host_d  = (state_d inside {ST_REL_HOST, ST_RUN});
        ready_d = (state_d == ST_RUN);
    end

    // State, counter, synchronizer and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            sync_q  <= 2'b00;
            fault_q <= 8'd0;
            adc_q   <= 1'b0;
            dsp_q   <= 1'b0;
            host_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            fault_q <= fault_d;
            adc_q   <= adc_d;
            dsp_q   <= dsp_d;
            host_q  <= host_d;
            ready_q <= ready_d;
        end
    end

    assign adc_rst_n   = adc_q;
    assign dsp_rst_n   = dsp_q;
    assign host_rst_n  = host_q;
    assign ready       = ready_q;
    assign state       = state_q;
    assign fault_count = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer with HOLD=4, LOCK=8, STAGE=4.
module tb_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       pll_locked;
    logic       soft_reset;
    logic       adc_rst_n;
    logic       dsp_rst_n;
    logic       host_rst_n;
    logic       ready;
    logic [2:0] state;
    logic [7:0] fault_count;

    int n_cmp;
    int n_err;
    int exp_fault;

    reset_sequencer #(
        .HOLD_CYCLES (4),
        .LOCK_CYCLES (8),
        .STAGE_DELAY (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .soft_reset  (soft_reset),
        .adc_rst_n   (adc_rst_n),
        .dsp_rst_n   (dsp_rst_n),
        .host_rst_n  (host_rst_n),
        .ready       (ready),
        .state       (state),
        .fault_count (fault_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected state at edge e after HOLD entry (or reset release) with lock held.
    function automatic logic [2:0] exp_state(input int e);
        if (e < 4)       return 3'd0;
        else if (e < 12) return 3'd1;
        else if (e < 16) return 3'd2;
        else if (e < 20) return 3'd3;
        else if (e < 24) return 3'd4;
        else             return 3'd5;
    endfunction

    // {adc_rst_n, dsp_rst_n, host_rst_n, ready} expected in each state.
    function automatic logic [3:0] exp_bits(input logic [2:0] st);
        case (st)
            3'd2:    return 4'b1000;
            3'd3:    return 4'b1100;
            3'd4:    return 4'b1110;
            3'd5:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [7:0] f);
        check_eq({tag, "_state"}, {29'd0, state}, {29'd0, st});
        check_eq({tag, "_rst"}, {28'd0, adc_rst_n, dsp_rst_n, host_rst_n, ready}, {28'd0, exp_bits(st)});
        check_eq({tag, "_fault"}, {24'd0, fault_count}, {24'd0, f});
    endtask

    // Step n edges with lock held, checking the release timeline on every edge.
    task automatic run_timeline(input string tag, input int n, input int soft_at, input logic [7:0] f);
        for (int e = 1; e <= n; e++) begin
            soft_reset = (e == soft_at) ? 1'b1 : 1'b0;
            @(posedge clock);
            #1;
            check_all($sformatf("%s_e%0d", tag, e), exp_state(e), f);
        end
        soft_reset = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        pll_locked = 1'b1;
        soft_reset = 1'b0;

        // Power-up with lock held throughout.
        #12;
        check_all("por", 3'd0, 8'd0);
        @(negedge clock);
        reset = 1'b1;
        run_timeline("pwrup", 24, 0, 8'd0);

        // Async reset from RUN, then lock glitch inside WAIT_LOCK.
        #2;
        reset      = 1'b0;
        pll_locked = 1'b0;
        #1;
        check_all("rst_run", 3'd0, 8'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            if (e == 5)  pll_locked = 1'b1;
            if (e == 10) pll_locked = 1'b0;
            if (e == 11) pll_locked = 1'b1;
            step(1);
            if (e == 4)  check_all("glitch_e4", 3'd1, 8'd0);
            if (e == 12) check_all("glitch_e12", 3'd1, 8'd0);
            if (e == 19) check_all("glitch_e19", 3'd1, 8'd0);
            if (e == 20) check_all("glitch_e20", 3'd2, 8'd0);
        end
        step(12);
        check_all("glitch_run", 3'd5, 8'd0);

        // Lock loss in RUN: three edges to HOLD, then an identical re-run.
        pll_locked = 1'b0;
        step(2);
        check_all("loss_e2", 3'd5, 8'd0);
        step(1);
        check_all("loss_e3", 3'd0, 8'd1);
        pll_locked = 1'b1;
        run_timeline("rerun", 16, 0, 8'd1);

        // Soft reset just after entering REL_DSP.
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        check_all("soft_dsp", 3'd0, 8'd1);
        run_timeline("soft_rerun", 24, 0, 8'd1);

        // Simultaneous soft reset and lock loss in RUN, repeated into saturation.
        exp_fault = 1;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            step(2);
            soft_reset = 1'b1;
            step(1);
            soft_reset = 1'b0;
            exp_fault  = (exp_fault < 255) ? exp_fault + 1 : 255;
            check_all($sformatf("both_%0d", i), 3'd0, exp_fault[7:0]);
            pll_locked = 1'b1;
            step(24);
        end
        check_eq("sat_final", {24'd0, fault_count}, 32'd255);

        // Async reset mid-REL_HOST between edges, then soft reset ignored in HOLD.
        pll_locked = 1'b0;
        step(3);
        pll_locked = 1'b1;
        run_timeline("pre_async", 21, 0, 8'd255);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_host", 3'd0, 8'd0);
        step(2);
        @(negedge clock);
        reset = 1'b1;
        run_timeline("post_async", 24, 2, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
